req_arbiter16: RTL

- Sequential arbiter that shares one downstream resource among 16 requesters.
- Selects a single winner per arbitration, either round-robin or fixed-priority. Fixed priority follows the team's priority-encoder convention: lowest index wins.
- Holds the grant until the winner releases its request.
- Outputs a one-hot grant vector plus the encoded 4-bit winner ID for the shared datapath mux.

---
 rtl/req_arbiter16.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/req_arbiter16.sv
// 16-way request arbiter: round-robin or fixed-priority, grant held until released.
// Optional macro ARB_TIMEOUT_EN adds a MAX_HOLD-cycle forced release with a timeout pulse.
module req_arbiter16 #(
  parameter int N        = 16,
  parameter int IDW      = 4,
  parameter int RR       = 1,
  parameter int MAX_HOLD = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  if ((1 << IDW) != N || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
    $error("req_arbiter16: IDW must be clog2(N) and MAX_HOLD must be 2..255");
  end

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic           gnt_valid_q, gnt_valid_d;
  logic           timeout_q, timeout_d;
  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] idx;
  logic           released;
  logic           force_off;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_q, hold_d;
`endif

  // Search upward from ptr with wrap; descending loop leaves the nearest hit.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = ptr_q + IDW'(k);
      if (req[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  assign released = ~req[gnt_id_q];

`ifdef ARB_TIMEOUT_EN
  assign force_off = req[gnt_id_q] && (hold_q >= HOLD_LAST);
`else
  assign force_off = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_d      = hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (en && win_found) begin
          gnt_d         = '0;
          gnt_d[win_id] = 1'b1;
          gnt_id_d      = win_id;
          gnt_valid_d   = 1'b1;
          state_d       = GRANT;
`ifdef ARB_TIMEOUT_EN
          hold_d        = '0;
`endif
        end
      end
      GRANT: begin
        // A voluntary release wins over a simultaneous timeout.
        if (released || force_off) begin
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          state_d     = IDLE;
          timeout_d   = ~released;
          if (RR != 0) begin
            ptr_d = gnt_id_q + IDW'(1);
          end
        end
`ifdef ARB_TIMEOUT_EN
        else begin
          hold_d = hold_q + 8'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
`ifdef ARB_TIMEOUT_EN
      hold_q      <= hold_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule
